// File: rtl/fifo_wr_ptr_gray_if.sv
// Write-side handshake bundle between the pixel writer, the FIFO memory and
// the read-domain pointer logic. The slave modport is the pointer manager.
interface fifo_wr_ptr_gray_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  wr_en_i;
  logic [ADDR_WIDTH:0]   rd_ptr_gray_i;
  logic                  wr_inc_o;
  logic [ADDR_WIDTH-1:0] wr_addr_o;
  logic [ADDR_WIDTH:0]   wr_ptr_gray_o;
  logic                  full_o;
  logic                  almost_full_o;
  logic [ADDR_WIDTH:0]   wr_level_o;
  logic                  overflow_o;

  modport master (
    output wr_en_i,
    output rd_ptr_gray_i,
    input  wr_inc_o,
    input  wr_addr_o,
    input  wr_ptr_gray_o,
    input  full_o,
    input  almost_full_o,
    input  wr_level_o,
    input  overflow_o
  );

  modport slave (
    input  wr_en_i,
    input  rd_ptr_gray_i,
    output wr_inc_o,
    output wr_addr_o,
    output wr_ptr_gray_o,
    output full_o,
    output almost_full_o,
    output wr_level_o,
    output overflow_o
  );
endinterface

// File: rtl/fifo_wr_ptr_gray.sv
// Write-side pointer manager for the dual-clock pixel FIFO.
// Keeps the binary write pointer, publishes a registered Gray copy to the
// read domain, synchronizes the read Gray pointer in, and derives the
// full / almost-full / level / overflow indications from the synchronized
// read pointer. Flags are computed from next-state values so they settle on
// the same edge the pointer moves.
module fifo_wr_ptr_gray #(
  parameter int ADDR_WIDTH   = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = 12
) (
  input logic              clk,
  input logic              rst,
  fifo_wr_ptr_gray_if.slave bus
);
  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] AFULL_LVL = PW'(AFULL_THRESH);

  logic [ADDR_WIDTH:0] bin_q;
  logic [ADDR_WIDTH:0] bin_next;
  logic [ADDR_WIDTH:0] gray_next;
  logic [ADDR_WIDTH:0] gray_q;
  logic [ADDR_WIDTH:0] sync_q [SYNC_STAGES];
  logic [ADDR_WIDTH:0] rd_sync;
  logic [ADDR_WIDTH:0] rd_bin;
  logic [ADDR_WIDTH:0] level_next;
  logic [ADDR_WIDTH:0] level_q;
  logic [ADDR_WIDTH:0] full_cmp;
  logic                accept;
  logic                full_q;
  logic                afull_q;
  logic                ovf_q;

  // A write is taken only when the FIFO is not full; the pointer then advances
  // by one and wraps naturally at 2^(ADDR_WIDTH+1).
  assign accept     = bus.wr_en_i & ~full_q;
  assign bin_next   = bin_q + {{ADDR_WIDTH{1'b0}}, accept};
  assign gray_next  = bin_next ^ (bin_next >> 1);
  assign rd_sync    = sync_q[SYNC_STAGES-1];
  assign level_next = bin_next - rd_bin;
  // Full when the write pointer is exactly one depth ahead: in Gray code that
  // is the read pointer with its two top bits inverted.
  assign full_cmp   = {~rd_sync[ADDR_WIDTH:ADDR_WIDTH-1], rd_sync[ADDR_WIDTH-2:0]};

  // Gray-to-binary of the synchronized read pointer: each binary bit is the
  // XOR of all Gray bits at and above it.
  always_comb begin
    rd_bin = '0;
    for (int i = 0; i <= ADDR_WIDTH; i++) begin
      rd_bin[i] = ^(rd_sync >> i);
    end
  end

  // Multi-stage synchronizer bringing the read domain's Gray pointer into clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= bus.rd_ptr_gray_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Pointer, registered Gray output and status flags, all from next-state values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q   <= '0;
      gray_q  <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      bin_q   <= bin_next;
      gray_q  <= gray_next;
      full_q  <= (gray_next == full_cmp);
      afull_q <= (level_next >= AFULL_LVL);
      level_q <= level_next;
      ovf_q   <= bus.wr_en_i & full_q;
    end
  end

  assign bus.wr_inc_o      = accept;
  assign bus.wr_addr_o     = bin_q[ADDR_WIDTH-1:0];
  assign bus.wr_ptr_gray_o = gray_q;
  assign bus.full_o        = full_q;
  assign bus.almost_full_o = afull_q;
  assign bus.wr_level_o    = level_q;
  assign bus.overflow_o    = ovf_q;
endmodule

// File: tb/tb_fifo_wr_ptr_gray.sv
// Self-checking bench for fifo_wr_ptr_gray (ADDR_WIDTH=4, SYNC_STAGES=2,
// AFULL_THRESH=12). A driver issues one directed vector per clock and pushes
// the expected response into a queue; a monitor pops and compares every cycle
// a vector is outstanding. Asynchronous reset behaviour is checked directly.
module tb_fifo_wr_ptr_gray;
  typedef struct {
    logic       inc;
    logic [3:0] addr;
    logic [4:0] gray;
    logic       full;
    logic       afull;
    logic [4:0] level;
    logic       ovf;
    bit         hand;
    logic [4:0] h_gray;
    logic [4:0] h_level;
    logic       h_full;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  int m_bin;
  int m_s0;
  int m_s1;
  bit m_full;

  fifo_wr_ptr_gray_if #(.ADDR_WIDTH(4)) bus ();

  fifo_wr_ptr_gray #(
    .ADDR_WIDTH  (4),
    .SYNC_STAGES (2),
    .AFULL_THRESH(12)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // 10 ns write clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [4:0] bin2gray(input int b);
    logic [4:0] v;
    v = 5'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic cmp(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Direct check used while reset is asserted: everything cleared, wr_inc_o tracks wr_en_i.
  task automatic checkOutput(input string tag);
    cmp({tag, "_gray"},  int'(bus.wr_ptr_gray_o), 0);
    cmp({tag, "_addr"},  int'(bus.wr_addr_o), 0);
    cmp({tag, "_full"},  int'(bus.full_o), 0);
    cmp({tag, "_afull"}, int'(bus.almost_full_o), 0);
    cmp({tag, "_level"}, int'(bus.wr_level_o), 0);
    cmp({tag, "_ovf"},   int'(bus.overflow_o), 0);
    cmp({tag, "_inc"},   int'(bus.wr_inc_o), int'(bus.wr_en_i));
  endtask

  task automatic modelReset();
    m_bin  = 0;
    m_s0   = 0;
    m_s1   = 0;
    m_full = 1'b0;
  endtask

  // One clock of stimulus: drive inputs at the falling edge and push the
  // response expected around the following rising edge.
  task automatic applyStimulus(input bit we, input int rdv, input bit hand = 1'b0,
                               input logic [4:0] h_gray = '0, input logic [4:0] h_level = '0,
                               input logic h_full = 1'b0);
    exp_t e;
    int   nb;
    int   lvl;
    bit   acc;
    @(negedge clk);
    bus.wr_en_i       = we;
    bus.rd_ptr_gray_i = bin2gray(rdv);
    acc       = we && !m_full;
    nb        = (m_bin + int'(acc)) % 32;
    lvl       = (nb - m_s1 + 32) % 32;
    e.inc     = acc;
    e.addr    = 4'(m_bin % 16);
    e.gray    = bin2gray(nb);
    e.level   = 5'(lvl);
    e.full    = (lvl == 16);
    e.afull   = (lvl >= 12);
    e.ovf     = we && m_full;
    e.hand    = hand;
    e.h_gray  = h_gray;
    e.h_level = h_level;
    e.h_full  = h_full;
    exp_q.push_back(e);
    m_bin  = nb;
    m_full = e.full;
    m_s1   = m_s0;
    m_s0   = rdv % 32;
  endtask

  // Wait, with a bound, for the monitor to consume every outstanding vector.
  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      @(posedge clk);
      #2;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain_timeout actual=%0d required=0 pending", exp_q.size());
    end
  endtask

  // Monitor: sample the combinational strobe/address once inputs settle,
  // then the registered outputs just after the rising edge.
  initial begin
    logic       inc_s;
    logic [3:0] addr_s;
    exp_t       e;
    forever begin
      @(negedge clk);
      #2;
      inc_s  = bus.wr_inc_o;
      addr_s = bus.wr_addr_o;
      @(posedge clk);
      #1;
      if (exp_q.size() != 0 && !rst) begin
        e = exp_q.pop_front();
        cmp("inc",   int'(inc_s), int'(e.inc));
        cmp("addr",  int'(addr_s), int'(e.addr));
        cmp("gray",  int'(bus.wr_ptr_gray_o), int'(e.gray));
        cmp("full",  int'(bus.full_o), int'(e.full));
        cmp("afull", int'(bus.almost_full_o), int'(e.afull));
        cmp("level", int'(bus.wr_level_o), int'(e.level));
        cmp("ovf",   int'(bus.overflow_o), int'(e.ovf));
        if (e.hand) begin
          cmp("hand_gray",  int'(bus.wr_ptr_gray_o), int'(e.h_gray));
          cmp("hand_level", int'(bus.wr_level_o), int'(e.h_level));
          cmp("hand_full",  int'(bus.full_o), int'(e.h_full));
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    modelReset();
    rst               = 1'b1;
    bus.wr_en_i       = 1'b0;
    bus.rd_ptr_gray_i = '0;
    #1;
    checkOutput("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Fill: 16 writes against a stationary read pointer.
    for (int i = 1; i <= 15; i++) applyStimulus(1'b1, 0);
    applyStimulus(1'b1, 0, 1'b1, 5'b11000, 5'd16, 1'b1);

    // Writes attempted while full.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 0);
    applyStimulus(1'b0, 0);

    // One read frees a slot; flags follow after the synchronizer delay.
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1);
    applyStimulus(1'b1, 1, 1'b1, 5'b11001, 5'd16, 1'b1);

    // Wrap: read pointer trails the write pointer by 8.
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, (m_bin + 24) % 32);

    // Empty out, then build level 9 for the reset test.
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, m_bin);
    begin
      int rd_hold;
      rd_hold = m_bin;
      for (int i = 0; i < 9; i++) applyStimulus(1'b1, rd_hold);
    end
    drain();
    #1;
    rst         = 1'b1;
    bus.wr_en_i = 1'b1;
    #1;
    checkOutput("async_rst");
    @(negedge clk);
    bus.wr_en_i       = 1'b0;
    bus.rd_ptr_gray_i = '0;
    modelReset();
    #1;
    checkOutput("rst_hold");
    @(negedge clk);
    rst = 1'b0;

    // Write and read advance together at level 15: no full, no overflow.
    for (int t = 1; t <= 20; t++) applyStimulus(1'b1, (t >= 14) ? t - 13 : 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit in case any wait misbehaves.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout actual=%0t required=finish", $time);
    $fatal(1, "[TB] timeout");
  end
endmodule
